input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Front-end stage for the control FSMs in this codebase. It takes the raw, asynchronous, bouncy x/y switch inputs and delivers clean synchronous levels x and y to the downstream state machine, plus one-cycle edge strobes.
- Each channel has a 2-flop synchronizer, a counter-based debouncer and an edge detector.
- A combined step strobe lets the downstream FSM advance exactly once per accepted input change.

Parameters:
- DEB_CYCLES, 4, consecutive synchronized cycles a new value must persist before acceptance; legal 1..2**CNT_W.
- CNT_W, 3, debounce counter width per channel.

Ports:
- clk  in  1  system clock, rising-edge.
- res  in  1  asynchronous active-low reset; 0 clears all state immediately.
- x_raw  in  1  raw asynchronous x input.
- y_raw  in  1  raw asynchronous y input.
- x  out  1  debounced synchronous x level, feeds the FSM x input.
- y  out  1  debounced synchronous y level, feeds the FSM y input.
- x_rise  out  1  one-cycle pulse when x goes 0->1.
- x_fall  out  1  one-cycle pulse when x goes 1->0.
- y_rise  out  1  one-cycle pulse when y goes 0->1.
- y_fall  out  1  one-cycle pulse when y goes 1->0.
- step  out  1  one-cycle pulse when x or y changed on this edge.

Behaviour:
- Reset (res=0, async): all sync flops, counters, levels and pulses are 0. All outputs read 0 while res=0. Deassertion is sampled on the next rising edge.
- Synchronizer, per channel:
  - s1 <= raw, s2 <= s1.
  - Only s2 is used downstream; raw never reaches logic directly.
- Debouncer, per channel (registers lvl = output x or y, cnt):
  - s2 == lvl: cnt <= 0.
  - s2 != lvl and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - s2 != lvl and cnt == DEB_CYCLES-1: lvl <= s2, cnt <= 0, and the accept event fires.
  - A mismatch run shorter than DEB_CYCLES clears cnt the first cycle s2 matches lvl again. lvl is unchanged (glitch rejected).
- Latency: raw held at a new value from edge 1 gives s1 at edge 1, s2 at edge 2, and lvl updated at edge DEB_CYCLES+2.
  - DEB_CYCLES=4: x changes at edge 6.
  - DEB_CYCLES=1: x changes at edge 3.
- Edge strobes (registered, same edge as lvl update):
  - x_rise <= accept & s2.
  - x_fall <= accept & ~s2.
  - y_rise and y_fall are the same for channel y.
  - Each strobe is high exactly one cycle, coincident with the new level, and is never high on consecutive cycles. The minimum spacing between accepts on one channel is DEB_CYCLES cycles.
- step <= accept_x | accept_y.
  - Simultaneous accepts on both channels give a single one-cycle step, with both channels' edge strobes high in that cycle.
- Channels are fully independent. The x counter is never affected by y activity.
- Counter never exceeds DEB_CYCLES-1, so no wrap-around is possible.
- Reset mid-count clears cnt and lvl.
  - After release, if raw is still 1, acceptance requires a full new DEB_CYCLES+2 edges.
  - Reset asserted while lvl=1 gives x=0 with no x_fall pulse.
- No combinational path from any input to any output; all outputs are flop outputs.

Test Plan:
- Reset: res=0 with x_raw=y_raw=1 for 3 cycles -> all 7 outputs 0 throughout. Release with raw still 1, DEB_CYCLES=4 -> x=y=1 at the 6th edge after release, with x_rise=y_rise=step=1 for exactly that cycle.
- Clean press: x_raw 0->1 held 10 cycles, DEB_CYCLES=4 -> x=1 at edge 6, x_rise=1 only at edge 6, step=1 only at edge 6. Then x_raw->0 -> x=0 and x_fall=1, 6 edges later.
- Glitch rejection: x_raw pulses 1 for 3 cycles (one fewer than DEB_CYCLES=4), then 0 -> x stays 0, no x_rise, no step, cnt back to 0.
- Bounce: x_raw toggles 1,0,1,0,1 (one cycle each) then holds 1 -> exactly one x_rise, occurring 6 edges after the final 0->1.
- Simultaneous: x_raw and y_raw rise on the same edge -> x_rise=y_rise=1 and step=1 in the same single cycle.
- Reset mid-operation: x=1 stable, assert res=0 mid-cycle -> x drops to 0 asynchronously with no x_fall. With DEB_CYCLES=1 after release and raw=1, x=1 at edge 3.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Switch-input bundle between the raw x/y switches and the control FSM front end.
// The master drives the raw switches; the slave (the conditioner) returns clean levels and strobes.
interface input_conditioner_if;
    logic x_raw;
    logic y_raw;
    logic x;
    logic y;
    logic x_rise;
    logic x_fall;
    logic y_rise;
    logic y_fall;
    logic step;

    modport master (
        output x_raw, y_raw,
        input  x, y, x_rise, x_fall, y_rise, y_fall, step
    );

    modport slave (
        input  x_raw, y_raw,
        output x, y, x_rise, x_fall, y_rise, y_fall, step
    );
endinterface

// File: rtl/input_conditioner.sv
// Two-channel switch conditioner: 2-flop synchronizer, counter debouncer and
// registered edge/step strobes for the x and y inputs of the control FSMs.
module input_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input logic                 clk,
    input logic                 res,
    input_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    // Channel 0 is x, channel 1 is y throughout.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       lvl_q;
    logic [1:0]       lvl_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       accept_d;
    logic [1:0]       rise_q;
    logic [1:0]       rise_d;
    logic [1:0]       fall_q;
    logic [1:0]       fall_d;
    logic             step_q;
    logic             step_d;

    // A channel accepts its synchronized value once it has disagreed with the
    // held level for DEB_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        lvl_d    = lvl_q;
        accept_d = '0;
        rise_d   = '0;
        fall_d   = '0;
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch] = '0;
            if (sync2_q[ch] != lvl_q[ch]) begin
                if (cnt_q[ch] == DEB_LAST) begin
                    accept_d[ch] = 1'b1;
                    lvl_d[ch]    = sync2_q[ch];
                    rise_d[ch]   = sync2_q[ch];
                    fall_d[ch]   = ~sync2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
        end
        step_d = |accept_d;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            step_q  <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            sync1_q <= {bus.y_raw, bus.x_raw};
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            step_q  <= step_d;
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign bus.x      = lvl_q[0];
    assign bus.y      = lvl_q[1];
    assign bus.x_rise = rise_q[0];
    assign bus.x_fall = fall_q[0];
    assign bus.y_rise = rise_q[1];
    assign bus.y_fall = fall_q[1];
    assign bus.step   = step_q;

endmodule
